// File: rtl/trex_pkg.sv
// Shared types and constants for the T-rex video path: colour classes, the
// 3/3/2 RGB constants and the default screen geometry.
package trex_pkg;

    // BLANK is encoded as zero so a freshly reset pipeline stage drives black.
    typedef enum logic [1:0] {
        CLS_BLANK = 2'd0,
        CLS_BG    = 2'd1,
        CLS_GREY  = 2'd2,
        CLS_WHITE = 2'd3
    } colour_class_e;

    localparam logic [7:0] RGB_WHITE = 8'hFF;
    localparam logic [7:0] RGB_BLACK = 8'h00;

    localparam int SCREEN_W_DEF = 640;
    localparam int SCREEN_H_DEF = 480;

    // Night mode inverts every visible class; the blanking interval stays black.
    function automatic logic [7:0] class_to_rgb(input colour_class_e cls, input logic night);
        logic [7:0] rgb;
        case (cls)
            CLS_WHITE: rgb = RGB_WHITE;
            CLS_GREY:  rgb = RGB_BLACK;
            CLS_BG:    rgb = RGB_WHITE;
            default:   rgb = RGB_BLACK;
        endcase
        if (night && (cls != CLS_BLANK)) begin
            rgb = ~rgb;
        end
        return rgb;
    endfunction

endpackage

// File: rtl/layer_compositor_collision_tracker.sv
// Player-vs-hazard overlap tracking: per-frame saturating pixel count,
// threshold pulse, sticky flag and per-layer hit flags of the previous frame.
module collision_tracker
    import trex_pkg::*;
#(
    parameter int                    NUM_LAYERS     = 4,
    parameter int                    PLAYER_LAYER   = 0,
    parameter logic [NUM_LAYERS-1:0] HIT_MASK       = '0,
    parameter int                    MIN_HIT_PIXELS = 4,
    parameter int                    CNT_W          = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pix_en,
    input  logic                  frame_start,
    input  logic [NUM_LAYERS-1:0] layer_grey,
    input  logic                  clear_hit,
    output logic                  collided,
    output logic                  collided_sticky,
    output logic [NUM_LAYERS-1:0] frame_hit_flags
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] THRESH_M1 = CNT_W'(MIN_HIT_PIXELS - 1);

    logic [NUM_LAYERS-1:0] ovl;
    logic [NUM_LAYERS-1:0] acc;
    logic [CNT_W-1:0]      cnt;
    logic                  any_ovl;
    logic                  hit;

    always_comb begin
        ovl               = layer_grey & HIT_MASK & {NUM_LAYERS{layer_grey[PLAYER_LAYER]}};
        ovl[PLAYER_LAYER] = 1'b0;
        any_ovl           = |ovl;
    end

    // On frame_start the count restarts from this pixel, so only a threshold
    // of one can be reached on that cycle.
    always_comb begin
        if (frame_start) begin
            hit = any_ovl && (MIN_HIT_PIXELS == 1);
        end else begin
            hit = any_ovl && (cnt == THRESH_M1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt             <= '0;
            acc             <= '0;
            frame_hit_flags <= '0;
            collided        <= 1'b0;
            collided_sticky <= 1'b0;
        end else begin
            if (pix_en) begin
                collided <= hit;
                if (frame_start) begin
                    frame_hit_flags <= acc;
                    acc             <= ovl;
                    cnt             <= CNT_W'(any_ovl);
                end else begin
                    acc <= acc | ovl;
                    if (any_ovl && (cnt != CNT_MAX)) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            end
            // A new collision outranks a simultaneous clear.
            if (pix_en && hit) begin
                collided_sticky <= 1'b1;
            end else if (clear_hit) begin
                collided_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/layer_compositor.sv
// Merges layer hit bits into a registered 3/3/2 RGB pixel with frame-synchronous
// night inversion, and forwards the grey layers to the collision tracker.
module layer_compositor
    import trex_pkg::*;
#(
    parameter int NUM_LAYERS     = 4,
    parameter int SCREEN_W       = SCREEN_W_DEF,
    parameter int SCREEN_H       = SCREEN_H_DEF,
    parameter int X_W            = 10,
    parameter int Y_W            = 9,
    parameter int PLAYER_LAYER   = 0,
    parameter     HIT_MASK       = 4'b1110,
    parameter int MIN_HIT_PIXELS = 4,
    parameter int CNT_W          = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pix_en,
    input  logic                  frame_start,
    input  logic [X_W-1:0]        x,
    input  logic [Y_W-1:0]        y,
    input  logic [NUM_LAYERS-1:0] layer_grey,
    input  logic [NUM_LAYERS-1:0] layer_white,
    input  logic                  night_req,
    input  logic                  clear_hit,
    output logic [7:0]            vga_rgb,
    output logic                  collided,
    output logic                  collided_sticky,
    output logic [NUM_LAYERS-1:0] frame_hit_flags,
    output logic                  night_active
);

    if ($bits(HIT_MASK) != NUM_LAYERS) begin : g_bad_mask
        $error("HIT_MASK width must equal NUM_LAYERS");
    end
    if ((MIN_HIT_PIXELS < 1) || ((MIN_HIT_PIXELS >> CNT_W) != 0)) begin : g_bad_thresh
        $error("MIN_HIT_PIXELS must be at least 1 and fit in CNT_W bits");
    end
    if ((PLAYER_LAYER < 0) || (PLAYER_LAYER >= NUM_LAYERS)) begin : g_bad_player
        $error("PLAYER_LAYER must index an existing layer");
    end

    localparam logic [NUM_LAYERS-1:0] HIT_MASK_V = HIT_MASK;
    localparam logic [X_W-1:0]        X_LIMIT    = X_W'(SCREEN_W);
    localparam logic [Y_W-1:0]        Y_LIMIT    = Y_W'(SCREEN_H);

    colour_class_e cls_next;
    colour_class_e cls_s1;

    always_comb begin
        if (|layer_white) begin
            cls_next = CLS_WHITE;
        end else if (|layer_grey) begin
            cls_next = CLS_GREY;
        end else if ((x < X_LIMIT) && (y < Y_LIMIT)) begin
            cls_next = CLS_BG;
        end else begin
            cls_next = CLS_BLANK;
        end
    end

    // Night mode changes in step with the first pixel of a frame, so that
    // pixel already leaves stage 2 in the new mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            cls_s1       <= CLS_BLANK;
            vga_rgb      <= RGB_BLACK;
            night_active <= 1'b0;
        end else if (pix_en) begin
            cls_s1  <= cls_next;
            vga_rgb <= class_to_rgb(cls_s1, night_active);
            if (frame_start) begin
                night_active <= night_req;
            end
        end
    end

    collision_tracker #(
        .NUM_LAYERS     (NUM_LAYERS),
        .PLAYER_LAYER   (PLAYER_LAYER),
        .HIT_MASK       (HIT_MASK_V),
        .MIN_HIT_PIXELS (MIN_HIT_PIXELS),
        .CNT_W          (CNT_W)
    ) u_collision_tracker (
        .clk             (clk),
        .rst             (rst),
        .pix_en          (pix_en),
        .frame_start     (frame_start),
        .layer_grey      (layer_grey),
        .clear_hit       (clear_hit),
        .collided        (collided),
        .collided_sticky (collided_sticky),
        .frame_hit_flags (frame_hit_flags)
    );

endmodule

// File: tb/tb_layer_compositor.sv
// Bench for layer_compositor: directed scenarios plus random traffic, every
// cycle compared against a pixel-history / per-frame-count reference model.
module tb_layer_compositor;

    localparam int          MIN_HITS = 4;
    localparam logic [3:0]  MASK     = 4'b1110;

    logic       clk = 1'b0;
    logic       rst;
    logic       pix_en;
    logic       frame_start;
    logic [9:0] x;
    logic [8:0] y;
    logic [3:0] layer_grey;
    logic [3:0] layer_white;
    logic       night_req;
    logic       clear_hit;
    logic [7:0] vga_rgb;
    logic       collided;
    logic       collided_sticky;
    logic [3:0] frame_hit_flags;
    logic       night_active;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    layer_compositor #(
        .NUM_LAYERS     (4),
        .SCREEN_W       (640),
        .SCREEN_H       (480),
        .X_W            (10),
        .Y_W            (9),
        .PLAYER_LAYER   (0),
        .HIT_MASK       (4'b1110),
        .MIN_HIT_PIXELS (MIN_HITS),
        .CNT_W          (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pix_en          (pix_en),
        .frame_start     (frame_start),
        .x               (x),
        .y               (y),
        .layer_grey      (layer_grey),
        .layer_white     (layer_white),
        .night_req       (night_req),
        .clear_hit       (clear_hit),
        .vga_rgb         (vga_rgb),
        .collided        (collided),
        .collided_sticky (collided_sticky),
        .frame_hit_flags (frame_hit_flags),
        .night_active    (night_active)
    );

    // Reference state: the pixel waiting in the pipe, the frame's overlap tally.
    logic [7:0] m_rgb_pend;
    logic [7:0] m_rgb;
    logic       m_night;
    logic       m_col;
    logic       m_sticky;
    logic [3:0] m_flags;
    logic [3:0] m_acc;
    int         m_frame_hits;

    function automatic logic [7:0] ref_colour(input logic [3:0] w, input logic [3:0] g,
                                              input logic [9:0] px, input logic [8:0] py,
                                              input logic night);
        logic [7:0] base;
        bit         blank;
        blank = 0;
        if (w != 0)                         base = 8'hFF;
        else if (g != 0)                    base = 8'h00;
        else if (px < 640 && py < 480)      base = 8'hFF;
        else begin base = 8'h00; blank = 1; end
        return (night && !blank) ? ~base : base;
    endfunction

    function automatic void model_update();
        logic [3:0] ovl;
        bit         hit_now;
        hit_now = 0;
        if (rst) begin
            m_rgb_pend   = 8'h00;
            m_rgb        = 8'h00;
            m_night      = 1'b0;
            m_col        = 1'b0;
            m_sticky     = 1'b0;
            m_flags      = 4'h0;
            m_acc        = 4'h0;
            m_frame_hits = 0;
            return;
        end
        if (pix_en) begin
            ovl = 4'h0;
            for (int k = 1; k < 4; k++)
                if (layer_grey[0] && layer_grey[k] && MASK[k]) ovl[k] = 1'b1;
            if (frame_start) begin
                m_night      = night_req;
                m_flags      = m_acc;
                m_acc        = 4'h0;
                m_frame_hits = 0;
            end
            m_acc = m_acc | ovl;
            if (ovl != 0) begin
                m_frame_hits++;
                hit_now = (m_frame_hits == MIN_HITS);
            end
            m_col      = hit_now;
            m_rgb      = m_rgb_pend;
            m_rgb_pend = ref_colour(layer_white, layer_grey, x, y, m_night);
        end
        if (pix_en && hit_now) m_sticky = 1'b1;
        else if (clear_hit)    m_sticky = 1'b0;
    endfunction

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic pe, input logic fs, input logic [9:0] px, input logic [8:0] py,
                        input logic [3:0] g, input logic [3:0] w, input logic nr, input logic clr);
        pix_en      = pe;
        frame_start = fs;
        x           = px;
        y           = py;
        layer_grey  = g;
        layer_white = w;
        night_req   = nr;
        clear_hit   = clr;
        @(posedge clk);
        model_update();
        #1;
        check_val("vga_rgb",         vga_rgb,                m_rgb);
        check_val("collided",        {7'b0, collided},       {7'b0, m_col});
        check_val("collided_sticky", {7'b0, collided_sticky},{7'b0, m_sticky});
        check_val("frame_hit_flags", {4'b0, frame_hit_flags},{4'b0, m_flags});
        check_val("night_active",    {7'b0, night_active},   {7'b0, m_night});
    endtask

    initial begin
        logic nr;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step(1, 0, 10, 10, 4'b0101, 4'b0011, 1, 0);
        rst = 1'b0;

        // colour classes
        step(1, 1, 10, 10, 4'b0000, 4'b0001, 0, 0);
        step(1, 0, 10, 10, 4'b0010, 4'b0000, 0, 0);
        step(1, 0, 10, 10, 4'b0000, 4'b0000, 0, 0);
        step(1, 0, 640, 10, 4'b0000, 4'b0000, 0, 0);
        step(1, 0, 10, 480, 4'b0000, 4'b0000, 0, 0);
        step(1, 0, 639, 479, 4'b0000, 4'b0000, 0, 0);

        // night requested mid-frame, takes effect at next frame_start
        step(1, 0, 10, 10, 4'b0010, 4'b0000, 1, 0);
        step(1, 0, 10, 10, 4'b0000, 4'b0000, 1, 0);
        step(1, 1, 10, 10, 4'b0010, 4'b0000, 1, 0);
        step(1, 0, 10, 10, 4'b0000, 4'b0000, 0, 0);
        step(1, 0, 700, 10, 4'b0000, 4'b0000, 0, 0);
        step(1, 0, 10, 10, 4'b0000, 4'b1000, 0, 0);
        step(1, 1, 10, 10, 4'b0000, 4'b0000, 0, 0);
        step(1, 0, 10, 10, 4'b0000, 4'b0000, 0, 0);

        // threshold: fourth overlapping pixel pulses once
        step(1, 1, 10, 10, 4'b0000, 4'b0000, 0, 0);
        for (int i = 0; i < 7; i++) step(1, 0, 10, 10, 4'b0101, 4'b0000, 0, 0);
        step(1, 0, 10, 10, 4'b0000, 4'b0000, 0, 1);
        step(1, 0, 10, 10, 4'b0000, 4'b0000, 0, 0);

        // clear on the same cycle as the pulse, then a pix_en stall
        step(1, 1, 10, 10, 4'b0101, 4'b0000, 0, 0);
        step(1, 0, 10, 10, 4'b0101, 4'b0000, 0, 0);
        step(1, 0, 10, 10, 4'b0101, 4'b0000, 0, 0);
        step(1, 0, 10, 10, 4'b0101, 4'b0000, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 700, 10, 4'b0101, 4'b0001, 1, 0);
        step(1, 0, 10, 10, 4'b0000, 4'b0000, 0, 1);
        step(1, 1, 10, 10, 4'b0101, 4'b0000, 0, 0);
        step(1, 0, 10, 10, 4'b0101, 4'b0000, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 10, 10, 4'b0101, 4'b0000, 0, 0);
        step(1, 0, 10, 10, 4'b0101, 4'b0000, 0, 0);
        step(1, 0, 10, 10, 4'b0101, 4'b0000, 0, 0);
        step(1, 0, 10, 10, 4'b0000, 4'b0000, 0, 1);

        // no overlap without both player and hazard
        step(1, 1, 10, 10, 4'b0000, 4'b0000, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 0, 10, 10, 4'b0001, 4'b0000, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 0, 10, 10, 4'b1110, 4'b0000, 0, 0);

        // per-layer frame flags
        step(1, 1, 10, 10, 4'b0000, 4'b0000, 0, 0);
        step(1, 0, 10, 10, 4'b0011, 4'b0000, 0, 0);
        step(1, 0, 10, 10, 4'b1001, 4'b0000, 0, 0);
        step(1, 0, 10, 10, 4'b0000, 4'b0000, 0, 0);
        step(1, 1, 10, 10, 4'b0000, 4'b0000, 0, 0);
        step(1, 0, 10, 10, 4'b0000, 4'b0000, 0, 0);
        step(1, 1, 10, 10, 4'b0101, 4'b0000, 0, 0);
        step(1, 0, 10, 10, 4'b0000, 4'b0000, 0, 0);

        // long frame: counter must saturate, never re-pulse
        step(1, 1, 10, 10, 4'b0000, 4'b0000, 0, 1);
        for (int i = 0; i < 300; i++) step(1, 0, 10, 10, 4'b0101, 4'b0000, 0, 0);
        step(1, 1, 10, 10, 4'b0000, 4'b0000, 0, 0);

        // random traffic, including occasional mid-frame reset
        nr = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] g, w;
            if ($urandom_range(0, 15) == 0) nr = ~nr;
            g = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            w = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'h0;
            rst = ($urandom_range(0, 499) == 0);
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0),
                 10'($urandom), 9'($urandom), g, w, nr, ($urandom_range(0, 15) == 0));
        end
        rst = 1'b0;
        step(1, 1, 10, 10, 4'b0000, 4'b0000, 0, 0);
        step(1, 0, 10, 10, 4'b0000, 4'b0000, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
